// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle EX hold, jump redirect/flush, stall counter.
// Zero-latency control outputs derived from registered state plus current inputs; no backpressure of its own.
module pipe_ctrl #(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             ex_busy_i,
    input  logic             ex_load_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             clear_cnt_i,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             id_ex_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             pc_load_o,
    output logic [31:0]      pc_load_addr_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        BUSY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hz;
    logic pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, pc_load;
    logic any_act;

    assign hz = ex_load_i && (ex_rd_addr_i != 5'd0) &&
                ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        id_ex_hold  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_load     = 1'b0;
        case (state_q)
            RUN, BUSY: begin
                if (ex_busy_i) begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    id_ex_hold = 1'b1;
                    state_d    = BUSY;
                end else if (jump_en_i) begin
                    pc_load     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    fcnt_d      = FLUSH_INIT;
                    state_d     = FLUSH;
                end else if (hz && state_q == RUN) begin
                    // BUSY exit never stalls: the load that finished is not the one in ID's shadow
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            STALL: begin
                pc_hold     = 1'b1;
                if_id_hold  = 1'b1;
                id_ex_flush = 1'b1;
                state_d     = RUN;
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (fcnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign any_act = pc_hold | if_id_hold | id_ex_hold | if_id_flush | id_ex_flush;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_cnt_i) begin
            cnt_d = '0;
        end else if (any_act && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs mix in live inputs, so reset must gate them explicitly
    assign pc_hold_o      = rst_n & pc_hold;
    assign if_id_hold_o   = rst_n & if_id_hold;
    assign id_ex_hold_o   = rst_n & id_ex_hold;
    assign if_id_flush_o  = rst_n & if_id_flush;
    assign id_ex_flush_o  = rst_n & id_ex_flush;
    assign pc_load_o      = rst_n & pc_load;
    assign pc_load_addr_o = (rst_n && pc_load) ? jump_addr_i : 32'd0;
    assign state_o        = rst_n ? 2'(state_q) : 2'd0;
    assign stall_cnt_o    = cnt_q;

endmodule
